// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, control bundle layout and FSM states for the decode stage
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_IO_WAIT = 1'b1;

    typedef enum logic [0:0] {
        IDLE    = ST_IDLE,
        IO_WAIT = ST_IO_WAIT
    } fsm_state_t;

    // Field order is the bit order seen on the ctrl output, jr at bit 15
    typedef struct packed {
        logic       jr;
        logic       jal;
        logic       branch;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       sftmd;
        logic       i_format;
        logic       mem_or_io_to_reg;
        logic       io_read;
        logic       io_write;
        logic       illegal;
        logic       lui_auipc;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// rtl/ctrl_decode_stage_if.sv - fetch-side, execute-side and IO-side handshake bundle of the decode stage
interface ctrl_decode_stage_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rega7;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     ctrl;
    logic            io_req;
    logic            io_ack;
    logic            io_timeout;

    modport master (
        output in_valid, instr, rega7, out_ready, io_ack,
        input  in_ready, out_valid, ctrl, io_req, io_timeout
    );

    modport slave (
        input  in_valid, instr, rega7, out_ready, io_ack,
        output in_ready, out_valid, ctrl, io_req, io_timeout
    );

endinterface

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational RV32 instr/a7 to control bundle decoder; CTRL_ILLEGAL_TRAP_EN flags non-RV32I opcodes
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IO_RD_LO = 0,
    parameter int IO_RD_HI = 3,
    parameter int IO_WR_LO = 4,
    parameter int IO_WR_HI = 5
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rega7,
    output ctrl_t           ctrl
);

    localparam logic [XLEN-1:0] RD_LO = XLEN'(IO_RD_LO);
    localparam logic [XLEN-1:0] RD_HI = XLEN'(IO_RD_HI);
    localparam logic [XLEN-1:0] WR_LO = XLEN'(IO_WR_LO);
    localparam logic [XLEN-1:0] WR_HI = XLEN'(IO_WR_HI);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       known;
    logic       is_ecall;
    logic       a7_rd;
    logic       a7_wr;
    logic       i_fmt;
    logic       io_rd;
    logic       io_wr;

    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign is_ecall = (instr == ECALL_WORD);

    // Offset compare: values below the low bound wrap to large numbers and fall out of range
    assign a7_rd = (rega7 - RD_LO) <= (RD_HI - RD_LO);
    assign a7_wr = (rega7 - WR_LO) <= (WR_HI - WR_LO);

    assign known = (opc == OPC_R)      || (opc == OPC_I)     || (opc == OPC_LOAD)  ||
                   (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL)  ||
                   (opc == OPC_JALR)   || (opc == OPC_LUI)   || (opc == OPC_AUIPC) ||
                   (opc == OPC_FENCE)  || (opc == OPC_SYSTEM);

    assign i_fmt = (opc == OPC_I) || (opc == OPC_LOAD);
    assign io_rd = is_ecall && a7_rd;
    assign io_wr = is_ecall && a7_wr;

    always_comb begin
        ctrl                  = '0;
        ctrl.jr               = (opc == OPC_JALR);
        ctrl.jal              = (opc == OPC_JAL);
        ctrl.branch           = (opc == OPC_BRANCH);
        ctrl.mem_read         = (opc == OPC_LOAD);
        ctrl.mem_write        = (opc == OPC_STORE);
        ctrl.i_format         = i_fmt;
        ctrl.lui_auipc        = (opc == OPC_LUI) || (opc == OPC_AUIPC);
        ctrl.alu_src          = known && (opc != OPC_R);
        ctrl.alu_op           = {opc == OPC_R, opc == OPC_BRANCH};
        ctrl.sftmd            = ((opc == OPC_I) || (opc == OPC_R)) &&
                                ((f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3) || (f3 == 3'd5));
        ctrl.io_read          = io_rd;
        ctrl.io_write         = io_wr;
        ctrl.mem_or_io_to_reg = (opc == OPC_LOAD) || io_rd;
        ctrl.reg_write        = (opc == OPC_R) || i_fmt || (opc == OPC_JAL) || (opc == OPC_JALR) ||
                                (opc == OPC_LUI) || (opc == OPC_AUIPC) || io_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!known) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
`else
        ctrl.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered RV32 decode stage with IO-ECALL wait FSM and timeout; CTRL_ILLEGAL_TRAP_EN passes to the decoder
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IO_RD_LO = 0,
    parameter int IO_RD_HI = 3,
    parameter int IO_WR_LO = 4,
    parameter int IO_WR_HI = 5,
    parameter int IO_TMO   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    ctrl_decode_stage_if.slave   bus
);

    localparam logic [15:0] TMO_LAST = 16'(IO_TMO - 1);

    ctrl_t      dec;
    ctrl_t      ctrl_q;
    fsm_state_t state;
    logic [15:0] tmo_cnt;
    logic       out_valid_q;
    logic       io_req_q;
    logic       io_timeout_q;
    logic       accept;
    logic       is_io;

    ctrl_decode_comb #(
        .XLEN     (XLEN),
        .IO_RD_LO (IO_RD_LO),
        .IO_RD_HI (IO_RD_HI),
        .IO_WR_LO (IO_WR_LO),
        .IO_WR_HI (IO_WR_HI)
    ) u_decode (
        .instr (bus.instr),
        .rega7 (bus.rega7),
        .ctrl  (dec)
    );

    assign bus.in_ready   = !flush && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign is_io          = dec.io_read || dec.io_write;
    assign bus.out_valid  = out_valid_q;
    assign bus.ctrl       = ctrl_q;
    assign bus.io_req     = io_req_q;
    assign bus.io_timeout = io_timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ctrl_q       <= '0;
            out_valid_q  <= 1'b0;
            io_req_q     <= 1'b0;
            io_timeout_q <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            io_timeout_q <= 1'b0;
            if (accept) begin
                ctrl_q <= dec;
            end
            // Flush outranks accept and ack; accept is already blocked through in_ready
            if (flush) begin
                state       <= IDLE;
                out_valid_q <= 1'b0;
                io_req_q    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && is_io) begin
                            state       <= IO_WAIT;
                            io_req_q    <= 1'b1;
                            out_valid_q <= 1'b0;
                            tmo_cnt     <= '0;
                        end else if (accept) begin
                            out_valid_q <= 1'b1;
                        end else if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                    IO_WAIT: begin
                        if (bus.io_ack) begin
                            state       <= IDLE;
                            io_req_q    <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state        <= IDLE;
                            io_req_q     <= 1'b0;
                            io_timeout_q <= 1'b1;
                        end else if (tmo_cnt != 16'hFFFF) begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - self-checking bench for ctrl_decode_stage with a cycle reference model
module tb_ctrl_decode_stage;

    localparam int TMO = 8;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_LW    = 32'h00012083;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_SLLI  = 32'h00109093;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [15:0] BAD_CTRL = 16'h0002;
`else
    localparam logic [15:0] BAD_CTRL = 16'h0000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    ctrl_decode_stage_if #(.XLEN(32)) bus ();

    ctrl_decode_stage #(
        .XLEN     (32),
        .IO_RD_LO (0),
        .IO_RD_HI (3),
        .IO_WR_LO (4),
        .IO_WR_HI (5),
        .IO_TMO   (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    bit          m_wait = 1'b0;
    bit          m_ov   = 1'b0;
    bit          m_req  = 1'b0;
    bit          m_tmo  = 1'b0;
    logic [15:0] m_ctrl = 16'h0;
    int          cyc    = 0;
    int          deadline = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-instruction-class truth table, assembled into the 16-bit bundle at the end
    function automatic logic [15:0] model_decode(input logic [31:0] ins, input logic [31:0] a7);
        logic [6:0] op;
        logic [2:0] f;
        bit jr, jal, br, rw, mr, mw, as, sf, ifm, ior, iow, ill, lu;
        bit [1:0] ao;
        op = ins[6:0];
        f  = ins[14:12];
        {jr, jal, br, rw, mr, mw, as, sf, ifm, ior, iow, ill, lu} = '0;
        ao = 2'b00;
        case (op)
            7'h33: begin rw = 1; ao = 2'b10; sf = (f == 1 || f == 2 || f == 3 || f == 5); end
            7'h13: begin rw = 1; as = 1; ifm = 1; sf = (f == 1 || f == 2 || f == 3 || f == 5); end
            7'h03: begin rw = 1; mr = 1; as = 1; ifm = 1; end
            7'h23: begin mw = 1; as = 1; end
            7'h63: begin br = 1; as = 1; ao = 2'b01; end
            7'h6F: begin jal = 1; rw = 1; as = 1; end
            7'h67: begin jr = 1; rw = 1; as = 1; end
            7'h37, 7'h17: begin lu = 1; rw = 1; as = 1; end
            7'h0F: as = 1;
            7'h73: begin
                as = 1;
                if (ins == 32'h73) begin
                    ior = (a7 < 4);
                    iow = (a7 == 4 || a7 == 5);
                    rw  = ior;
                end
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                ill = 1;
`endif
            end
        endcase
        return {jr, jal, br, rw, mr, mw, as, ao, sf, ifm, mr | ior, ior, iow, ill, lu};
    endfunction

    task automatic model_step();
        bit rdy, acc, io;
        logic [15:0] d;
        if (reset) begin
            m_wait = 0; m_ov = 0; m_req = 0; m_tmo = 0; m_ctrl = 16'h0;
        end else begin
            m_tmo = 0;
            rdy = !flush && !m_wait && (!m_ov || bus.out_ready);
            acc = bus.in_valid && rdy;
            d   = model_decode(bus.instr, bus.rega7);
            io  = d[3] | d[2];
            if (acc) m_ctrl = d;
            if (flush) begin
                m_wait = 0; m_ov = 0; m_req = 0;
            end else if (m_wait) begin
                if (bus.io_ack) begin
                    m_wait = 0; m_req = 0; m_ov = 1;
                end else if (cyc == deadline) begin
                    m_wait = 0; m_req = 0; m_tmo = 1;
                end
            end else if (acc && io) begin
                m_wait = 1; m_req = 1; m_ov = 0; deadline = cyc + TMO;
            end else if (acc) begin
                m_ov = 1;
            end else if (bus.out_ready) begin
                m_ov = 0;
            end
        end
        cyc++;
    endtask

    initial begin : compare
        forever begin
            @(posedge clock);
            model_step();
            #1;
            chk("cmp_out_valid", bus.out_valid, m_ov);
            chk("cmp_io_req", bus.io_req, m_req);
            chk("cmp_io_timeout", bus.io_timeout, m_tmo);
            chk("cmp_in_ready", bus.in_ready, !flush && !m_wait && (!m_ov || bus.out_ready));
            if (m_ov) chk("cmp_ctrl", bus.ctrl, m_ctrl);
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] a7);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rega7    = a7;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] t_ins [6] = '{32'h73, I_BAD, I_SLLI, I_LUI, I_JAL, I_JALR};
    logic [31:0] t_a7  [6] = '{32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [15:0] t_exp [6] = '{16'h0200, BAD_CTRL, 16'h1260, 16'h1201, 16'h5200, 16'h9200};

    initial begin : stim
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.rega7     = 32'h0;
        bus.out_ready = 1'b1;
        bus.io_ack    = 1'b0;

        chk("pin_add", model_decode(I_ADD, 0), 16'h1100);
        chk("pin_lw", model_decode(I_LW, 0), 16'h1A30);
        chk("pin_sw", model_decode(I_SW, 0), 16'h0600);
        chk("pin_beq", model_decode(I_BEQ, 0), 16'h2280);
        chk("pin_ecall_rd", model_decode(I_ECALL, 2), 16'h1218);
        chk("pin_ecall_wr", model_decode(I_ECALL, 5), 16'h0204);

        repeat (3) @(negedge clock);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_io_req", bus.io_req, 0);
        chk("rst_io_timeout", bus.io_timeout, 0);
        chk("rst_ctrl", bus.ctrl, 0);
        reset = 1'b0;

        send(I_ADD, 0);
        chk("add_valid", bus.out_valid, 1);
        chk("add_ctrl", bus.ctrl, 16'h1100);
        @(negedge clock);
        chk("add_drained", bus.out_valid, 0);

        bus.in_valid = 1'b1; bus.instr = I_LW;
        @(negedge clock);
        chk("lw_ctrl", bus.ctrl, 16'h1A30);
        chk("lw_in_ready", bus.in_ready, 1);
        bus.instr = I_SW;
        @(negedge clock);
        chk("sw_ctrl", bus.ctrl, 16'h0600);
        chk("sw_in_ready", bus.in_ready, 1);
        bus.instr = I_BEQ;
        @(negedge clock);
        chk("beq_ctrl", bus.ctrl, 16'h2280);
        chk("beq_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("b2b_drained", bus.out_valid, 0);

        send(I_ECALL, 2);
        chk("iord_req", bus.io_req, 1);
        chk("iord_in_ready", bus.in_ready, 0);
        chk("iord_no_valid", bus.out_valid, 0);
        repeat (5) @(negedge clock);
        bus.io_ack = 1'b1;
        @(negedge clock);
        bus.io_ack = 1'b0;
        chk("iord_valid", bus.out_valid, 1);
        chk("iord_ctrl", bus.ctrl, 16'h1218);
        chk("iord_req_drop", bus.io_req, 0);
        @(negedge clock);

        send(I_ECALL, 5);
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_req_held", bus.io_req, 1);
            chk("tmo_not_early", bus.io_timeout, 0);
            @(negedge clock);
        end
        chk("tmo_pulse", bus.io_timeout, 1);
        chk("tmo_req_drop", bus.io_req, 0);
        chk("tmo_no_valid", bus.out_valid, 0);
        chk("tmo_idle", bus.in_ready, 1);
        @(negedge clock);
        chk("tmo_one_cycle", bus.io_timeout, 0);

        send(I_ECALL, 0);
        repeat (TMO - 1) @(negedge clock);
        bus.io_ack = 1'b1;
        @(negedge clock);
        chk("ackwin_valid", bus.out_valid, 1);
        chk("ackwin_no_pulse", bus.io_timeout, 0);
        chk("ackwin_ctrl", bus.ctrl, 16'h1218);
        @(negedge clock);
        bus.io_ack = 1'b0;
        chk("stray_ack_req", bus.io_req, 0);
        chk("stray_ack_valid", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        send(I_ADD, 0);
        bus.in_valid = 1'b1; bus.instr = I_LW;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_ctrl", bus.ctrl, 16'h1100);
            chk("hold_in_ready", bus.in_ready, 0);
            @(negedge clock);
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_valid", bus.out_valid, 0);

        bus.in_valid = 1'b1; bus.instr = I_ADD; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_beats_accept", bus.out_valid, 0);

        send(I_ECALL, 3);
        @(negedge clock);
        flush = 1'b1; bus.io_ack = 1'b1;
        @(negedge clock);
        flush = 1'b0; bus.io_ack = 1'b0;
        chk("flush_wait_req", bus.io_req, 0);
        chk("flush_wait_valid", bus.out_valid, 0);
        chk("flush_wait_tmo", bus.io_timeout, 0);
        repeat (TMO + 2) @(negedge clock);

        send(I_ECALL, 4);
        chk("iowr_req", bus.io_req, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("reset_wait_req", bus.io_req, 0);
        chk("reset_wait_valid", bus.out_valid, 0);

        for (int i = 0; i < 6; i++) begin
            send(t_ins[i], t_a7[i]);
            chk("tbl_valid", bus.out_valid, 1);
            chk("tbl_ctrl", bus.ctrl, t_exp[i]);
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
